// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART definitions: FSM state encoding, oversampling ratio,
//          data-bit count and the baud divider calculation. Shared by the
//          receiver and the transmitter.
// Rev    : 1.0  initial release
// ============================================================================
// Contents:
//   OVERSAMPLE    - oversample ticks per bit period (16)
//   DATA_BITS     - payload bits per frame (8)
//   OS_CNT_W      - width of an oversample tick counter
//   BIT_CNT_W     - width of a data-bit index counter
//   uart_state_t  - receiver FSM state type
//   c_ST_*        - receiver FSM state encodings
//   calc_div()    - clocks per oversample tick
// ============================================================================
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;

  localparam int unsigned OS_CNT_W   = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_CNT_W  = $clog2(DATA_BITS);

  typedef logic [2:0] uart_state_t;

  localparam logic [2:0] c_ST_IDLE      = 3'd0;
  localparam logic [2:0] c_ST_START     = 3'd1;
  localparam logic [2:0] c_ST_DATA      = 3'd2;
  localparam logic [2:0] c_ST_STOP      = 3'd3;
  localparam logic [2:0] c_ST_WAIT_IDLE = 3'd4;

  // Clocks per oversample tick, truncated. Clamped to 1 so a nonsensical
  // parameter pair still yields a working (if wrong-rate) counter.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    int unsigned v_div;
    if (baud == 0) begin
      v_div = 1;
    end else begin
      v_div = clk_hz / (baud * OVERSAMPLE);
    end
    if (v_div < 1) begin
      v_div = 1;
    end
    return v_div;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module : uart_baud_tick
// Brief  : Oversample tick generator. Pulses 'tick' for one clock every
//          DIV = CLOCK_FREQUENCY/(BAUD_RATE*16) clocks. The counter wraps
//          from DIV-1 to 0 and is held at 0 while 'clear' is high, so the
//          first tick after 'clear' drops arrives exactly DIV clocks later.
// Rev    : 1.0  initial release
// ============================================================================
// Ports:
//   clock  in  1  system clock, rising edge
//   reset  in  1  synchronous active-high reset
//   clear  in  1  hold counter at 0 (phase-align to an external event)
//   tick   out 1  one-cycle oversample strobe
// ============================================================================
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned BAUD_RATE       = 9600
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned c_DIV   = calc_div(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int unsigned c_CNT_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               w_at_last;

  assign w_at_last = (r_cnt == c_LAST);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (w_at_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_ONE;
    end
  end

  // Combinational strobe: the consumer sees it in the same cycle the counter
  // wraps, keeping the tick and the wrap in lock-step.
  assign tick = w_at_last;

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module : uart_rx
// Brief  : 8N1 UART receiver with 16x oversampling. The line is brought into
//          the clock domain by a 2-flop synchroniser, the start bit is
//          validated at its midpoint, and each data/stop bit is then sampled
//          16 ticks later (mid-bit). A good stop bit updates rx_data_out and
//          pulses rx_valid; a low stop bit pulses rx_frame_error and the
//          receiver waits for the line to return high before re-arming.
// Rev    : 1.0  initial release
// ============================================================================
// Ports:
//   clock           in  1  system clock, rising edge
//   reset           in  1  synchronous active-high reset
//   serial_rx       in  1  asynchronous serial line, idle high
//   rx_data_out     out 8  last correctly received byte
//   rx_valid        out 1  one-cycle pulse: rx_data_out newly updated
//   rx_frame_error  out 1  one-cycle pulse: stop bit sampled low
//   rx_busy         out 1  high whenever the FSM is not in IDLE
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned BAUD_RATE       = 9600
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 serial_rx,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_valid,
  output logic                 rx_frame_error,
  output logic                 rx_busy
);

  // Start bit is checked on the 8th tick (index 7), data/stop on the 16th.
  localparam logic [OS_CNT_W-1:0]  c_OS_MID  = OS_CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_CNT_W-1:0]  c_OS_LAST = OS_CNT_W'(OVERSAMPLE - 1);
  localparam logic [OS_CNT_W-1:0]  c_OS_ONE  = OS_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0] c_BIT_LAST = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] c_BIT_ONE  = BIT_CNT_W'(1);

  // --------------------------------------------------------------------------
  // Input synchroniser. Resets to the idle level so that reset release never
  // looks like a start bit.
  // --------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_rx;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

  // --------------------------------------------------------------------------
  // Oversample tick. Held at 0 while idle so the tick phase is referenced to
  // the detected start edge.
  // --------------------------------------------------------------------------
  uart_state_t r_state;
  logic        w_tick;
  logic        w_tick_clear;

  assign w_tick_clear = (r_state == c_ST_IDLE);

  uart_baud_tick #(
    .CLOCK_FREQUENCY (CLOCK_FREQUENCY),
    .BAUD_RATE       (BAUD_RATE)
  ) u_baud_tick (
    .clock (clock),
    .reset (reset),
    .clear (w_tick_clear),
    .tick  (w_tick)
  );

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  logic [OS_CNT_W-1:0]  r_os_cnt;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 w_os_mid;
  logic                 w_os_last;

  assign w_os_mid  = w_tick && (r_os_cnt == c_OS_MID);
  assign w_os_last = w_tick && (r_os_cnt == c_OS_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= c_ST_IDLE;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      // Status strobes are single-cycle by construction: cleared every cycle
      // and set only on the one edge that leaves STOP.
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;

      case (r_state)
        c_ST_IDLE: begin
          r_os_cnt  <= '0;
          r_bit_cnt <= '0;
          if (!w_rx) begin
            r_state <= c_ST_START;
          end
        end

        c_ST_START: begin
          if (w_os_mid) begin
            // Mid-start re-check rejects short glitches. The baud counter
            // wraps on this same edge, so clearing the tick index re-centres
            // all later samples on bit midpoints.
            r_os_cnt <= '0;
            if (w_rx) begin
              r_state <= c_ST_IDLE;
            end else begin
              r_state <= c_ST_DATA;
            end
          end else if (w_tick) begin
            r_os_cnt <= r_os_cnt + c_OS_ONE;
          end
        end

        c_ST_DATA: begin
          if (w_os_last) begin
            r_os_cnt <= '0;
            // LSB arrives first, so shift in from the top.
            r_shift  <= {w_rx, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == c_BIT_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= c_ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
            end
          end else if (w_tick) begin
            r_os_cnt <= r_os_cnt + c_OS_ONE;
          end
        end

        c_ST_STOP: begin
          if (w_os_last) begin
            r_os_cnt <= '0;
            if (w_rx) begin
              // Returning to IDLE half a bit early lets a back-to-back start
              // edge be caught on the first idle cycle.
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= c_ST_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= c_ST_WAIT_IDLE;
            end
          end else if (w_tick) begin
            r_os_cnt <= r_os_cnt + c_OS_ONE;
          end
        end

        c_ST_WAIT_IDLE: begin
          // Break / framing fault: re-arm only once the line is released.
          if (w_rx) begin
            r_state <= c_ST_IDLE;
          end
        end

        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign rx_data_out    = r_data;
  assign rx_valid       = r_valid;
  assign rx_frame_error = r_ferr;
  // Decoded from the registered state, so it drops on the same edge that
  // raises rx_valid.
  assign rx_busy        = (r_state != c_ST_IDLE);

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_uart_rx
// Brief  : Directed self-checking bench for uart_rx at 1.6 MHz / 10 kBd
//          (DIV = 10, 160 clocks per bit).
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 1600000;
  localparam int unsigned BAUD   = 10000;
  localparam int          BITCLK = 160;

  logic       clock     = 1'b0;
  logic       reset     = 1'b1;
  logic       serial_rx = 1'b1;
  logic [7:0] rx_data_out;
  logic       rx_valid;
  logic       rx_frame_error;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;

  uart_rx #(
    .CLOCK_FREQUENCY (CLK_HZ),
    .BAUD_RATE       (BAUD)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .serial_rx      (serial_rx),
    .rx_data_out    (rx_data_out),
    .rx_valid       (rx_valid),
    .rx_frame_error (rx_frame_error),
    .rx_busy        (rx_busy)
  );

  always #5 clock = ~clock;

  // --------------------------------------------------------------------------
  // Pulse monitor, sampled on the falling edge (away from the active edge).
  // --------------------------------------------------------------------------
  int         n_valid      = 0;
  int         n_ferr       = 0;
  int         n_both       = 0;
  int         n_wide       = 0;
  int         n_busy_valid = 0;
  logic       prev_valid   = 1'b0;
  logic       prev_ferr    = 1'b0;
  logic [7:0] got_q[$];

  always @(negedge clock) begin
    if (rx_valid === 1'b1) begin
      n_valid = n_valid + 1;
      got_q.push_back(rx_data_out);
    end
    if (rx_frame_error === 1'b1) n_ferr = n_ferr + 1;
    if (rx_valid === 1'b1 && rx_frame_error === 1'b1) n_both = n_both + 1;
    if (rx_valid === 1'b1 && rx_busy === 1'b1) n_busy_valid = n_busy_valid + 1;
    if ((rx_valid === 1'b1 && prev_valid === 1'b1) ||
        (rx_frame_error === 1'b1 && prev_ferr === 1'b1)) n_wide = n_wide + 1;
    prev_valid = rx_valid;
    prev_ferr  = rx_frame_error;
  end

  // Advance n rising edges, then step 1 ns past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive one 8N1 frame; the line is left at the stop-bit level.
  task automatic send_byte(input logic [7:0] b, input int bclk, input logic stop);
    serial_rx = 1'b0;
    cyc(bclk);
    for (int i = 0; i < 8; i++) begin
      serial_rx = b[i];
      cyc(bclk);
    end
    serial_rx = stop;
    cyc(bclk);
  endtask

  function automatic logic [7:0] got_at(input int idx);
    if (idx < got_q.size()) return got_q[idx];
    return 8'hxx;
  endfunction

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    cyc(5);
    checks++; if (rx_data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data_out); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    checks++; if (rx_frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", rx_frame_error); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    reset = 1'b0;
    cyc(20);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", rx_busy); end
  endtask

  task automatic test_single();
    int v0 = n_valid;
    int f0 = n_ferr;
    int q0 = got_q.size();
    send_byte(8'hA5, BITCLK, 1'b1);
    cyc(20);
    checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL single_valid_count: got %0d want 1", n_valid - v0); end
    checks++; if (got_at(q0) !== 8'hA5) begin errors++; $display("FAIL single_data_at_valid: got %h want a5", got_at(q0)); end
    checks++; if (rx_data_out !== 8'hA5) begin errors++; $display("FAIL single_data_hold: got %h want a5", rx_data_out); end
    checks++; if (n_ferr - f0 != 0) begin errors++; $display("FAIL single_ferr_count: got %0d want 0", n_ferr - f0); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b want 0", rx_busy); end
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid;
    int f0 = n_ferr;
    int q0 = got_q.size();
    send_byte(8'h00, BITCLK, 1'b1);
    send_byte(8'hFF, BITCLK, 1'b1);
    cyc(20);
    checks++; if (n_valid - v0 != 2) begin errors++; $display("FAIL b2b_valid_count: got %0d want 2", n_valid - v0); end
    checks++; if (got_at(q0) !== 8'h00) begin errors++; $display("FAIL b2b_first_data: got %h want 00", got_at(q0)); end
    checks++; if (got_at(q0 + 1) !== 8'hFF) begin errors++; $display("FAIL b2b_second_data: got %h want ff", got_at(q0 + 1)); end
    checks++; if (n_ferr - f0 != 0) begin errors++; $display("FAIL b2b_ferr_count: got %0d want 0", n_ferr - f0); end
  endtask

  task automatic test_glitch();
    int v0 = n_valid;
    int f0 = n_ferr;
    int k  = 0;
    serial_rx = 1'b0;
    cyc(40);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise: got %b want 1", rx_busy); end
    serial_rx = 1'b1;
    while (rx_busy !== 1'b0 && k < 100) begin
      cyc(1);
      k++;
    end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_clear: got %b want 0 within 100 clocks", rx_busy); end
    cyc(200);
    checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL glitch_valid_count: got %0d want 0", n_valid - v0); end
    checks++; if (n_ferr - f0 != 0) begin errors++; $display("FAIL glitch_ferr_count: got %0d want 0", n_ferr - f0); end
    checks++; if (rx_data_out !== 8'hFF) begin errors++; $display("FAIL glitch_data_hold: got %h want ff", rx_data_out); end
  endtask

  task automatic test_frame_error();
    int v0 = n_valid;
    int f0 = n_ferr;
    send_byte(8'h3C, BITCLK, 1'b0);
    cyc(2000);
    checks++; if (n_ferr - f0 != 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", n_ferr - f0); end
    checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL ferr_valid_count: got %0d want 0", n_valid - v0); end
    checks++; if (rx_data_out !== 8'hFF) begin errors++; $display("FAIL ferr_data_hold: got %h want ff", rx_data_out); end
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL ferr_wait_idle_busy: got %b want 1", rx_busy); end
    serial_rx = 1'b1;
    cyc(10);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_release_busy: got %b want 0", rx_busy); end
  endtask

  task automatic test_reset_midframe();
    int v0 = n_valid;
    int f0 = n_ferr;
    logic [7:0] b;
    b = 8'h5A;
    serial_rx = 1'b0;
    cyc(BITCLK);
    for (int i = 0; i < 4; i++) begin
      serial_rx = b[i];
      cyc(BITCLK);
    end
    serial_rx = b[4];
    cyc(BITCLK / 2);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL midframe_busy_before_reset: got %b want 1", rx_busy); end
    reset = 1'b1;
    cyc(1);
    checks++; if (rx_data_out !== 8'h00) begin errors++; $display("FAIL midframe_reset_data: got %h want 00", rx_data_out); end
    checks++; if (rx_valid !== 1'b0 || rx_frame_error !== 1'b0) begin errors++; $display("FAIL midframe_reset_pulses: got %b%b want 00", rx_valid, rx_frame_error); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midframe_reset_busy: got %b want 0", rx_busy); end
    cyc(2);
    reset = 1'b0;
    serial_rx = 1'b1;
    cyc(400);
    checks++; if (n_valid - v0 != 0 || n_ferr - f0 != 0) begin errors++; $display("FAIL midframe_no_pulse: got valid %0d ferr %0d want 0 0", n_valid - v0, n_ferr - f0); end
    send_byte(8'h81, BITCLK, 1'b1);
    cyc(20);
    checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL midframe_next_count: got %0d want 1", n_valid - v0); end
    checks++; if (rx_data_out !== 8'h81) begin errors++; $display("FAIL midframe_next_data: got %h want 81", rx_data_out); end
  endtask

  task automatic test_skew();
    int bclk;
    int v0;
    int f0;
    for (int s = 0; s < 2; s++) begin
      bclk = (s == 0) ? 155 : 165;
      v0   = n_valid;
      f0   = n_ferr;
      send_byte(8'h55, bclk, 1'b1);
      cyc(40);
      checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL skew_%0d_valid_count: got %0d want 1", bclk, n_valid - v0); end
      checks++; if (rx_data_out !== 8'h55) begin errors++; $display("FAIL skew_%0d_data: got %h want 55", bclk, rx_data_out); end
      checks++; if (n_ferr - f0 != 0) begin errors++; $display("FAIL skew_%0d_ferr: got %0d want 0", bclk, n_ferr - f0); end
    end
  endtask

  task automatic test_pulse_rules();
    checks++; if (n_both != 0) begin errors++; $display("FAIL rule_exclusive: got %0d overlaps want 0", n_both); end
    checks++; if (n_wide != 0) begin errors++; $display("FAIL rule_width: got %0d wide pulses want 0", n_wide); end
    checks++; if (n_busy_valid != 0) begin errors++; $display("FAIL rule_busy_low_at_valid: got %0d want 0", n_busy_valid); end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
    test_skew();
    test_pulse_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_uart_rx
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL take parameter CLOCK_FREQUENCY, default 50000000, the clock frequency in Hz.
REQ-002 The block SHALL take parameter BAUD_RATE, default 9600, the serial bit rate in baud.
REQ-003 Port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 Port serial_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 Port rx_data_out, output, 8 bits: last correctly received byte.
REQ-007 Port rx_valid, output, 1 bit: one-cycle pulse, rx_data_out newly updated.
REQ-008 Port rx_frame_error, output, 1 bit: one-cycle pulse, stop bit sampled low.
REQ-009 Port rx_busy, output, 1 bit: high from start-bit detection until return to IDLE.

Function
REQ-010 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-011 serial_rx SHALL pass through a 2-flop synchroniser; the synchroniser flops SHALL reset to 1.
REQ-012 Oversample tick SHALL pulse once every DIV = CLOCK_FREQUENCY/(BAUD_RATE*16) clocks (integer truncation); DIV=325 at defaults.
REQ-013 Tick counter SHALL wrap from DIV-1 to 0; it SHALL be held at 0 in IDLE and restart at 0 on start-bit detection.
REQ-014 States SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-015 IDLE -> START on a synchronised low level; rx_busy rises the same cycle.
REQ-016 START: at tick 8 (mid-bit) the line SHALL be sampled; if 1 (glitch), go to IDLE with no pulse; if 0, go to DATA and reset the tick count.
REQ-017 DATA: each bit SHALL be sampled after 16 ticks (mid-bit) into a shift register, LSB first; after bit 7, go to STOP.
REQ-018 STOP: sampled after 16 ticks; if 1, load rx_data_out, pulse rx_valid the next cycle, go to IDLE.
REQ-019 STOP sampled 0: rx_data_out SHALL be unchanged, rx_frame_error SHALL pulse the next cycle, go to WAIT_IDLE.
REQ-020 WAIT_IDLE SHALL stay until the synchronised line reads 1 (break condition), then go to IDLE.
REQ-021 rx_valid and rx_frame_error SHALL never be high simultaneously and SHALL be exactly 1 cycle wide.
REQ-022 rx_data_out SHALL hold its value until the next valid frame; there is no consumer handshake and no overrun flag.
REQ-023 A start edge arriving during STOP mid-sample processing SHALL be detected no later than 1 cycle after return to IDLE.
REQ-024 rx_busy SHALL be low in IDLE only; it is low in the same cycle that rx_valid pulses.

Reset
REQ-025 On reset: state IDLE, tick and bit counters 0, shift register 0, rx_data_out 0x00, rx_valid 0, rx_frame_error 0, rx_busy 0, synchroniser 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no pulse; reception restarts only on a new falling edge after reset release.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state encoding, OVERSAMPLE=16, DATA_BITS=8, and the DIV calculation, for reuse by uart_tx.
REQ-028 Tick generation SHALL be a sub-module uart_baud_tick (parameters CLOCK_FREQUENCY, BAUD_RATE; ports clock, reset, clear, tick).

Verification (bench params CLOCK_FREQUENCY=1600000, BAUD_RATE=10000 -> DIV=10, bit = 160 clocks)
REQ-029 Send 0xA5 with a valid stop bit -> rx_valid is 1 for exactly 1 cycle, rx_data_out=0xA5, rx_frame_error stays 0.
REQ-030 Send 0x00 then 0xFF back-to-back, with no idle gap -> two rx_valid pulses, data 0x00 then 0xFF.
REQ-031 Drive a 40-clock low glitch on an idle line -> no pulses; rx_busy returns to 0 within 100 clocks.
REQ-032 Send 0x3C with the stop bit held 0, then hold the line low for 2000 clocks -> one rx_frame_error pulse, rx_data_out unchanged, FSM stays in WAIT_IDLE until the line goes high.
REQ-033 Assert reset at data bit 4 of 0x5A -> all outputs 0 the cycle after reset; next frame 0x81 is received correctly.
REQ-034 Bit-period skew of +/-3% on the sender (155/165 clocks) with 0x55 -> received correctly.
